regfile_2r1w_pipe: RTL and testbench

//   Parametrised successor to the fixed 16x16 register bank and operand muxes: a
//   2-read / 1-write register file with registered operand outputs and a

---
 rtl/regfile_2r1w_pipe.sv | 105 ++++++++++
 tb/tb_regfile_2r1w_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_2r1w_pipe
//  Purpose  : 2-read / 1-write register file with write->read bypass and a
//             registered, valid/ready-handshaked operand pair output.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_2r1w_pipe #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_R0  = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdReq,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic              RdReqRdy,
    output logic              RdValid,
    input  logic              RdReady,
    output logic [DATA_W-1:0] RdDataA,
    output logic [DATA_W-1:0] RdDataB
);

    localparam logic [ADDR_W:0] c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [DATA_W-1:0] w_opa_d, w_opb_d;
    logic              w_wr_legal;
    logic              w_accept;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < c_NUM_REGS) && !(ZERO_R0 && (addr == '0));
    endfunction

    // Address checks come first so unmapped/zero registers never see the bypass.
    function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr_ok(addr)) begin
            if (w_wr_legal && (WrAddr == addr)) val = WrData;
            else                                 val = regs_q[addr];
        end
        return val;
    endfunction

    assign w_wr_legal = WrEn && addr_ok(WrAddr);
    assign RdReqRdy   = (state_q == EMPTY) || RdReady;
    assign w_accept   = RdReq && RdReqRdy;

    always_comb begin
        w_opa_d = operand(RdAddrA);
        w_opb_d = operand(RdAddrB);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (w_wr_legal) begin
            regs_q[WrAddr] <= WrData;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (w_accept)             state_d = FULL;
            FULL:    if (RdReady && !w_accept) state_d = EMPTY;
            default:                           state_d = EMPTY;
        endcase
    end

    // Operands are a snapshot taken at accept; they hold through stalls and bubbles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (w_accept) begin
            opa_q <= w_opa_d;
            opb_q <= w_opb_d;
        end
    end

    assign RdValid = (state_q == FULL);
    assign RdDataA = opa_q;
    assign RdDataB = opb_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_2r1w_pipe
//  Purpose  : Scoreboard bench for regfile_2r1w_pipe (12 regs, r0 hardwired).
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_2r1w_pipe;

    localparam int c_DW = 16;
    localparam int c_NR = 12;
    localparam int c_AW = 4;

    logic            Clk, Reset, WrEn, RdReq, RdReady;
    logic [c_AW-1:0] WrAddr, RdAddrA, RdAddrB;
    logic [c_DW-1:0] WrData, RdDataA, RdDataB;
    logic            RdReqRdy, RdValid;

    regfile_2r1w_pipe #(
        .DATA_W  (c_DW),
        .NUM_REGS(c_NR),
        .ADDR_W  (c_AW),
        .ZERO_R0 (1'b1)
    ) u_dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .RdReq   (RdReq),
        .RdAddrA (RdAddrA),
        .RdAddrB (RdAddrB),
        .RdReqRdy(RdReqRdy),
        .RdValid (RdValid),
        .RdReady (RdReady),
        .RdDataA (RdDataA),
        .RdDataB (RdDataB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [c_DW-1:0] mdl [16];
    logic            m_valid;
    logic [31:0]     exp_q [$];
    logic [c_DW-1:0] last_a, last_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [3:0] addr);
        return (int'(addr) < c_NR) && (addr != 4'd0);
    endfunction

    function automatic logic [c_DW-1:0] ref_op(input logic [3:0] addr, input logic we,
                                               input logic [3:0] wa, input logic [c_DW-1:0] wd);
        if (!legal(addr))                   return '0;
        if (we && legal(wa) && (wa == addr)) return wd;
        return mdl[addr];
    endfunction

    // Inputs change 1 time unit after a rising edge; model state advances after that edge.
    task automatic step(input logic req, input logic rdy, input logic [3:0] a, input logic [3:0] b,
                        input logic we, input logic [3:0] wa, input logic [c_DW-1:0] wd);
        logic        acc;
        logic [31:0] pair;
        RdReq = req; RdReady = rdy; RdAddrA = a; RdAddrB = b;
        WrEn = we; WrAddr = wa; WrData = wd;
        acc  = req && (!m_valid || rdy);
        pair = {ref_op(a, we, wa, wd), ref_op(b, we, wa, wd)};
        @(posedge Clk);
        #1;
        if (acc) exp_q.push_back(pair);
        if (we && legal(wa)) mdl[wa] = wd;
        m_valid = acc || (m_valid && !rdy);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        RdReq = 1'b0; WrEn = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        last_a = '0; last_b = '0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        #1;
        check("rst_valid", RdValid, 0);
        check("rst_dataA", RdDataA, 0);
        check("rst_dataB", RdDataB, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    // Monitor: every falling edge, compare the presented pair against the queue head.
    always @(negedge Clk) begin
        if (!Reset) begin
            check("valid", RdValid, (exp_q.size() != 0));
            check("reqrdy", RdReqRdy, (exp_q.size() == 0) || RdReady);
            if (exp_q.size() != 0) begin
                check("opA", RdDataA, exp_q[0][31:16]);
                check("opB", RdDataB, exp_q[0][15:0]);
                last_a = exp_q[0][31:16];
                last_b = exp_q[0][15:0];
                if (RdReady) void'(exp_q.pop_front());
            end else begin
                check("holdA", RdDataA, last_a);
                check("holdB", RdDataB, last_b);
            end
        end
    end

    initial begin
        Reset = 1'b1; RdReq = 1'b0; RdReady = 1'b0; WrEn = 1'b0;
        RdAddrA = '0; RdAddrB = '0; WrAddr = '0; WrData = '0;
        m_valid = 1'b0; last_a = '0; last_b = '0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // 1: read after reset
        step(1, 1, 4'd3, 4'd7, 0, 4'd0, 16'h0000);
        // 2: write then read same register on both ports
        step(0, 1, 4'd0, 4'd0, 1, 4'd5, 16'hBEEF);
        step(1, 1, 4'd5, 4'd5, 0, 4'd0, 16'h0000);
        // 3: same-cycle bypass, then plain read
        step(1, 1, 4'd2, 4'd5, 1, 4'd2, 16'h1234);
        step(1, 1, 4'd2, 4'd2, 0, 4'd0, 16'h0000);
        // 4: r0 hardwired, out-of-range write/read ignored
        step(0, 1, 4'd0, 4'd0, 1, 4'd0, 16'hFFFF);
        step(1, 1, 4'd0, 4'd13, 1, 4'd13, 16'hCAFE);
        step(1, 1, 4'd13, 4'd0, 0, 4'd0, 16'h0000);
        // 5: stall with writes underneath
        step(0, 1, 4'd0, 4'd0, 1, 4'd3, 16'h0011);
        step(0, 1, 4'd0, 4'd0, 1, 4'd4, 16'h0022);
        step(1, 0, 4'd3, 4'd4, 0, 4'd0, 16'h0000);
        for (int i = 0; i < 3; i++) step(1, 0, 4'd1, 4'd3, 1, 4'd3, 16'hA000 + 16'(i));
        step(1, 1, 4'd3, 4'd4, 0, 4'd0, 16'h0000);
        step(0, 1, 4'd0, 4'd0, 0, 4'd0, 16'h0000);
        // 6: back-to-back over r0..r7, then reset mid-stream
        for (int i = 1; i < 8; i++) step(0, 1, 4'd0, 4'd0, 1, 4'(i), 16'h1100 * 16'(i));
        for (int i = 0; i < 8; i++) step(1, 1, 4'(i), 4'(7 - i), 0, 4'd0, 16'h0000);
        step(1, 1, 4'd1, 4'd2, 0, 4'd0, 16'h0000);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 4'(i), 4'(i + 4), 0, 4'd0, 16'h0000);

        // Randomized traffic over the full address space, including unmapped registers
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0,
                 4'($urandom % 16), 4'($urandom % 16),
                 ($urandom % 2) != 0, 4'($urandom % 16), 16'($urandom));
            if (n == 200) do_reset();
        end

        step(0, 1, 4'd0, 4'd0, 0, 4'd0, 16'h0000);
        step(0, 1, 4'd0, 4'd0, 0, 4'd0, 16'h0000);
        @(negedge Clk);
        #1;
        check("drained", RdValid, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
